// File: rtl/dmux_stream.sv
// Registered 1-to-CHANNELS stream demultiplexer with valid/ready handshakes.
// Each channel has a one-entry holding register. Words with an out-of-range sel are dropped and flagged.
module dmux_stream #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_WIDTH-1:0]      in_sel,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      sel_err
);

    logic [CHANNELS-1:0] full_q, full_d;
    logic [WIDTH-1:0]    buf_q [CHANNELS];
    logic [WIDTH-1:0]    buf_d [CHANNELS];
    logic                sel_err_q, sel_err_d;

    logic [CHANNELS-1:0] sel_hot;
    logic                sel_ok;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] drain;

    // Decoding by equality avoids indexing past the last channel when sel is out of range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_hot = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_sel == SEL_WIDTH'(i)) begin
                sel_hot[i] = 1'b1;
                sel_ok     = 1'b1;
            end
        end
    end

    assign drain    = full_q & out_ready;
    assign in_ready = !sel_ok || (|(sel_hot & (~full_q | out_ready)));
    assign load     = sel_hot & {CHANNELS{in_valid && in_ready}};

    always_comb begin
        full_d    = (full_q & ~drain) | load;
        sel_err_d = in_valid && !sel_ok;
        for (int i = 0; i < CHANNELS; i++) begin
            buf_d[i] = load[i] ? in_data : buf_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            sel_err_q <= 1'b0;
            // NOTE: the data buffers are cleared too, so out_data is zero after reset without relying on gating alone.
            for (int i = 0; i < CHANNELS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
            full_q    <= full_d;
            sel_err_q <= sel_err_d;
            for (int i = 0; i < CHANNELS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign out_valid = full_q;
    assign sel_err   = sel_err_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = full_q[g] ? buf_q[g] : '0;
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Scoreboard bench for dmux_stream: a 4-channel instance with a per-channel expected-word queue,
// plus a 3-channel instance that exercises the out-of-range sel path.
module tb_dmux_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, sel_err;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid, out_ready;
    logic [31:0] out_data;

    logic        r3, v3, rdy3, se3;
    logic [7:0]  d3;
    logic [1:0]  s3;
    logic [2:0]  ov3, or3;
    logic [23:0] od3;

    dmux_stream #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err)
    );

    dmux_stream #(.WIDTH(8), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
        .clk(clk), .reset(r3), .in_valid(v3), .in_ready(rdy3),
        .in_data(d3), .in_sel(s3), .out_valid(ov3),
        .out_ready(or3), .out_data(od3), .sel_err(se3)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [4][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output transfers are decided by values that stay stable across the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_ch%0d: got %h expected no word", i, out_data[i*8 +: 8]);
                    end else begin
                        check($sformatf("sb_ch%0d", i), {24'b0, out_data[i*8 +: 8]}, {24'b0, exp_q[i].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
        r3 = 1'b1; v3 = 1'b0; d3 = '0; s3 = '0; or3 = '0;

        // Reset then idle
        step(); step();
        reset = 1'b0; r3 = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_out_data", out_data, 32'h0);
        check("rst_sel_err", sel_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Basic route to channel 2
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2;
        #1 check("route_in_ready", in_ready, 1'b1);
        exp_q[2].push_back(8'hA5);
        step();
        in_valid = 1'b0;
        #1;
        check("route_out_valid", out_valid, 4'b0100);
        check("route_out_data", out_data, 32'h00A5_0000);

        // Backpressure: channel 2 full and stalled
        in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd2;
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("stall_in_ready_%0d", c), in_ready, 1'b0);
            step();
        end
        out_ready = 4'b0100;
        #1 check("unstall_in_ready", in_ready, 1'b1);
        exp_q[2].push_back(8'h3C);
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        check("reload_out_valid", out_valid, 4'b0100);
        check("reload_out_data", out_data, 32'h003C_0000);

        // Independence: channel 0 loads while channel 2 stays stalled
        in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd0;
        #1 check("indep_in_ready", in_ready, 1'b1);
        exp_q[0].push_back(8'h11);
        step();
        in_valid = 1'b0;
        #1;
        check("indep_out_valid", out_valid, 4'b0101);
        check("indep_out_data", out_data, 32'h003C_0011);
        out_ready = 4'b1111;
        step();

        // Streaming 1..16 into channel 1 with every consumer ready
        for (int w = 1; w <= 16; w++) begin
            in_valid = 1'b1; in_data = 8'(w); in_sel = 2'd1;
            #1;
            check($sformatf("stream_in_ready_%0d", w), in_ready, 1'b1);
            if (w > 1) check($sformatf("stream_valid_%0d", w), out_valid, 4'b0010);
            exp_q[1].push_back(8'(w));
            step();
        end
        in_valid = 1'b0;
        #1;
        check("stream_last_valid", out_valid, 4'b0010);
        check("stream_last_data", out_data, 32'h0000_1000);
        step();
        #1;
        check("drained_out_valid", out_valid, 4'b0000);
        for (int i = 0; i < 4; i++) check($sformatf("sb_left_ch%0d", i), exp_q[i].size(), 0);

        // Out-of-range sel on the 3-channel instance
        v3 = 1'b1; d3 = 8'h22; s3 = 2'd0;
        step();
        d3 = 8'hFF; s3 = 2'd3;
        #1 check("bad_in_ready", rdy3, 1'b1);
        step();
        v3 = 1'b0;
        #1;
        check("bad_sel_err", se3, 1'b1);
        check("bad_out_valid", ov3, 3'b001);
        check("bad_out_data", od3, 24'h00_0022);
        step();
        #1;
        check("bad_sel_err_clear", se3, 1'b0);
        check("bad_out_valid_kept", ov3, 3'b001);

        v3 = 1'b1; s3 = 2'd3;
        step(); step();
        v3 = 1'b0;
        #1 check("b2b_sel_err_hold", se3, 1'b1);
        step();
        #1 check("b2b_sel_err_clear", se3, 1'b0);

        // Reset dominates a simultaneous load
        v3 = 1'b1; d3 = 8'h55; s3 = 2'd1; r3 = 1'b1;
        step();
        v3 = 1'b0; r3 = 1'b0;
        #1;
        check("midrst_out_valid", ov3, 3'b000);
        check("midrst_out_data", od3, 24'h0);
        check("midrst_sel_err", se3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
